// File: rtl/lambert_shade_stage_if.sv
// Bus bundle for lambert_shade_stage: upstream sample inputs and the ready/valid pixel output.
interface lambert_shade_stage_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          valid_in;
  logic          hit_in;
  logic          obj_sel;
  logic [95:0]   surfaceNormal;
  logic [95:0]   surfaceLightVector;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [23:0]   pixel_rgb;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output valid_in, hit_in, obj_sel, surfaceNormal, surfaceLightVector, pixel_ready,
    input  pixel_valid, pixel_rgb, fifo_count, overflow
  );

  modport slave (
    input  valid_in, hit_in, obj_sel, surfaceNormal, surfaceLightVector, pixel_ready,
    output pixel_valid, pixel_rgb, fifo_count, overflow
  );
endinterface

// File: rtl/lambert_shade_stage.sv
// Lambert diffuse shade: clamp(N.L,0,1) in Q8.24 scales the object colour, 3-cycle pipeline into an RGB888 FIFO.
// Define SHADE_AMBIENT_EN to add the AMBIENT floor to the clamped intensity.
module lambert_shade_stage #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [23:0] BG_COLOUR   = 24'h000000,
  parameter logic [23:0] OBJ0_COLOUR = 24'hFF4020,
  parameter logic [23:0] OBJ1_COLOUR = 24'h20A0FF
`ifdef SHADE_AMBIENT_EN
  ,
  parameter logic [31:0] AMBIENT     = 32'h00200000
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  lambert_shade_stage_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic signed [31:0] Q_ONE = 32'sh01000000;

  // Q8.24 x Q8.24 -> Q8.24, truncating (keeps product bits [55:24])
  function automatic logic signed [31:0] q_mul(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return 32'(p >>> 24);
  endfunction

  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [8:0] k);
    logic [16:0] p;
    p = 17'(c) * 17'(k);
    return 8'(p >> 8);
  endfunction

  // ---------------- S1: per-axis products ----------------
  logic signed [31:0] px_d, py_d, pz_d;
  logic signed [31:0] s1_px_q, s1_py_q, s1_pz_q;
  logic               s1_valid_q, s1_hit_q, s1_obj_q;

  always_comb begin
    px_d = q_mul(signed'(bus.surfaceNormal[95:64]), signed'(bus.surfaceLightVector[95:64]));
    py_d = q_mul(signed'(bus.surfaceNormal[63:32]), signed'(bus.surfaceLightVector[63:32]));
    pz_d = q_mul(signed'(bus.surfaceNormal[31:0]),  signed'(bus.surfaceLightVector[31:0]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_obj_q   <= 1'b0;
      s1_px_q    <= '0;
      s1_py_q    <= '0;
      s1_pz_q    <= '0;
    end else begin
      s1_valid_q <= bus.valid_in;
      s1_hit_q   <= bus.hit_in;
      s1_obj_q   <= bus.obj_sel;
      s1_px_q    <= px_d;
      s1_py_q    <= py_d;
      s1_pz_q    <= pz_d;
    end
  end

  // ---------------- S2: dot product, clamp, colour scale factor ----------------
  logic signed [31:0] dot;
  logic [31:0]        clamped;
  logic [8:0]         k_d;
  logic [8:0]         s2_k_q;
  logic               s2_valid_q, s2_hit_q, s2_obj_q;
`ifdef SHADE_AMBIENT_EN
  logic [32:0]        lit;
`endif

  always_comb begin
    dot = s1_px_q + s1_py_q + s1_pz_q;
    if (dot < 0)          clamped = '0;
    else if (dot > Q_ONE) clamped = Q_ONE;
    else                  clamped = dot;
`ifdef SHADE_AMBIENT_EN
    lit = 33'(clamped) + 33'(AMBIENT);
    if (lit > 33'(Q_ONE)) lit = 33'(Q_ONE);
    k_d = 9'(lit >> 16);
`else
    k_d = 9'(clamped >> 16);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_obj_q   <= 1'b0;
      s2_k_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_hit_q;
      s2_obj_q   <= s1_obj_q;
      s2_k_q     <= k_d;
    end
  end

  // ---------------- S3: colour scale, written straight into the FIFO ----------------
  logic [23:0] base_c, rgb_c;

  always_comb begin
    base_c = s2_obj_q ? OBJ1_COLOUR : OBJ0_COLOUR;
    rgb_c  = BG_COLOUR;
    if (s2_hit_q) begin
      rgb_c = {scale_ch(base_c[23:16], s2_k_q),
               scale_ch(base_c[15:8],  s2_k_q),
               scale_ch(base_c[7:0],   s2_k_q)};
    end
  end

  // ---------------- Output FIFO ----------------
  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   head_q, head_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic          rd_en, wr_en;

  always_comb begin
    rd_en      = valid_q & bus.pixel_ready;
    wr_en      = s2_valid_q & ((count_q < CW'(FIFO_DEPTH)) | rd_en);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    if (wr_en && !rd_en) count_d = count_q + CW'(1);
    if (!wr_en && rd_en) count_d = count_q - CW'(1);
    if (s2_valid_q && !wr_en) overflow_d = 1'b1;
    valid_d = (count_d != '0);
    // Registered head: a write landing on the next head slot bypasses the array
    head_d = mem_q[rd_ptr_d];
    if (wr_en && (wr_ptr_q == rd_ptr_d)) head_d = rgb_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[wr_ptr_q] <= rgb_c;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.pixel_valid = valid_q;
  assign bus.pixel_rgb   = head_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_lambert_shade_stage.sv
// Scoreboard bench for lambert_shade_stage: directed vectors push expected pixels, a monitor pops on each handshake.
module tb_lambert_shade_stage;
  localparam logic [31:0] ONE  = 32'h01000000;
  localparam logic [31:0] HALF = 32'h00800000;
  localparam logic [31:0] Q75  = 32'h00C00000;
  localparam logic [31:0] NEG1 = 32'hFF000000;
  localparam logic [31:0] NEGQ = 32'hFFC00000;
`ifdef SHADE_AMBIENT_EN
  localparam int AOFF = 2;
`else
  localparam int AOFF = 0;
`endif
  // obj0 colour at intensity n/16, n = 1..12
  localparam logic [23:0] RAMP [12] = '{24'h0F0402, 24'h1F0804, 24'h2F0C06, 24'h3F1008,
                                        24'h4F140A, 24'h5F180C, 24'h6F1C0E, 24'h7F2010,
                                        24'h8F2412, 24'h9F2814, 24'hAF2C16, 24'hBF3018};

  typedef struct {
    logic [23:0] rgb;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  lambert_shade_stage_if #(.FIFO_DEPTH(8)) bus ();

  lambert_shade_stage #(.FIFO_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return {x, y, z};
  endfunction

  function automatic logic [23:0] ramp(input int n);
    return RAMP[n - 1 + AOFF];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [23:0] rgb, input string tag);
    exp_t e;
    e.rgb = rgb;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; holds the sample for exactly one cycle
  task automatic send(input logic hit, input logic obj, input logic [95:0] n,
                      input logic [95:0] l);
    bus.valid_in           = 1'b1;
    bus.hit_in             = hit;
    bus.obj_sel            = obj;
    bus.surfaceNormal      = n;
    bus.surfaceLightVector = l;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: %0d pixels still pending after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic latency_check(input string name);
    @(negedge clk) chk({name, "_c1"}, 32'(bus.pixel_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) chk({name, "_c2"}, 32'(bus.pixel_valid), 32'd0);
    @(posedge clk);
    @(negedge clk) chk({name, "_c3"}, 32'(bus.pixel_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pixel must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.pixel_valid && bus.pixel_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pixel: got %06h, expected no pixel", bus.pixel_rgb);
      end else begin
        e = exp_q.pop_front();
        if (bus.pixel_rgb !== e.rgb) begin
          n_err++;
          $display("FAIL %s: got %06h, expected %06h", e.tag, bus.pixel_rgb, e.rgb);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_in           = 1'b0;
    bus.hit_in             = 1'b0;
    bus.obj_sel            = 1'b0;
    bus.surfaceNormal      = '0;
    bus.surfaceLightVector = '0;
    bus.pixel_ready        = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.pixel_valid), 32'd0);
    chk("rst_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_ovf",   32'(bus.overflow),   32'd0);
    chk("rst_rgb",   32'(bus.pixel_rgb),  32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Full intensity, latency of exactly three edges
    push(24'hFF4020, "full_obj0");
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, ONE));
    latency_check("lat");

    // Back-to-back directed vectors with the sink always ready
    push(ramp(8), "half_obj0");
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, HALF));
`ifdef SHADE_AMBIENT_EN
    push(24'h1F0804, "neg_obj0");
`else
    push(24'h000000, "neg_obj0");
`endif
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, NEG1));
    push(24'h000000, "miss_bg");
    send(1'b0, 1'b0, v3($urandom, $urandom, $urandom), v3($urandom, $urandom, $urandom));
    push(24'h20A0FF, "full_obj1");
    send(1'b1, 1'b1, v3(ONE, 0, 0), v3(ONE, 0, 0));
    push(ramp(8), "mixed_half");
    send(1'b1, 1'b0, v3(HALF, HALF, 0), v3(HALF, HALF, 0));
    push(24'hFF4020, "clamp_high");
    send(1'b1, 1'b0, v3(Q75, Q75, 0), v3(Q75, Q75, 0));
`ifdef SHADE_AMBIENT_EN
    push(24'h1F0804, "neg_quarter");
`else
    push(24'h000000, "neg_quarter");
`endif
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, NEGQ));
    wait_drain("drain_basic", 20);

    // Overflow: 10 samples into a stalled 8-deep FIFO
    bus.pixel_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) push(ramp(i), $sformatf("ovf_px%0d", i));
      send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, 32'(i) << 20));
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("ovf_count", 32'(bus.fifo_count), 32'd8);
    chk("ovf_flag",  32'(bus.overflow),   32'd1);
    chk("ovf_head",  32'(bus.pixel_rgb),  32'(ramp(1)));
    @(posedge clk);
    #1;
    bus.pixel_ready = 1'b1;
    wait_drain("drain_ovf", 30);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Asynchronous reset with pixels queued and in flight
    bus.pixel_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, ONE));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.pixel_valid), 32'd0);
    chk("arst_count", 32'(bus.fifo_count),  32'd0);
    chk("arst_ovf",   32'(bus.overflow),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus.pixel_ready = 1'b1;
    push(ramp(8), "post_rst");
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, HALF));
    latency_check("lat_rst");
    wait_drain("drain_rst", 20);
    chk("post_rst_count", 32'(bus.fifo_count), 32'd0);

    // Full FIFO: read and write on the same edge
    bus.pixel_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      push(ramp(i), $sformatf("full_px%0d", i));
      send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, 32'(i) << 20));
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("full_count", 32'(bus.fifo_count), 32'd8);
    @(posedge clk);
    #1;
    push(ramp(9), "full_px9");
    send(1'b1, 1'b0, v3(0, 0, ONE), v3(0, 0, 32'd9 << 20));
    @(posedge clk);
    #1;
    bus.pixel_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.pixel_ready = 1'b0;
    @(negedge clk);
    chk("full_rw_count", 32'(bus.fifo_count), 32'd8);
    chk("full_rw_ovf",   32'(bus.overflow),   32'd0);
    chk("full_rw_head",  32'(bus.pixel_rgb),  32'(ramp(2)));
    @(posedge clk);
    #1;
    bus.pixel_ready = 1'b1;
    wait_drain("drain_full", 30);
    chk("end_count", 32'(bus.fifo_count), 32'd0);
    chk("end_ovf",   32'(bus.overflow),   32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
